// File: rtl/pref_pkg.sv
// Shared types, default sizes and the line-alignment helper for the
// prefetch issue queue.
package pref_pkg;

  typedef logic [63:0] addr_t;

  localparam int DEF_DEPTH        = 8;
  localparam int DEF_LINE_BITS    = 6;
  localparam int DEF_RECENT_COUNT = 4;

  // Clear the low line_bits bits of a byte address to get its cache line.
  function automatic addr_t line_align(input addr_t addr, input int unsigned line_bits);
    addr_t mask;
    mask = '1;
    mask = mask << line_bits;
    return addr & mask;
  endfunction

endpackage

// File: rtl/pref_recent_filter.sv
// Small filter of recently issued lines. Written round-robin on every
// issue handshake; entries are only overwritten, never aged out.
module pref_recent_filter
  import pref_pkg::*;
#(
  parameter int RECENT_COUNT = DEF_RECENT_COUNT
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  wr_en,
  input  addr_t wr_line,
  input  addr_t line1,
  input  addr_t line2,
  input  addr_t line3,
  output logic  hit1,
  output logic  hit2,
  output logic  hit3
);

  localparam int PW = (RECENT_COUNT > 1) ? $clog2(RECENT_COUNT) : 1;

  addr_t                   lines [RECENT_COUNT];
  logic [RECENT_COUNT-1:0] vld;
  logic [PW-1:0]           ptr;

  // Slot write and round-robin pointer advance; reset invalidates all slots.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld <= '0;
      ptr <= '0;
      for (int i = 0; i < RECENT_COUNT; i++) lines[i] <= '0;
    end else if (wr_en) begin
      lines[ptr] <= wr_line;
      vld[ptr]   <= 1'b1;
      ptr        <= (ptr == PW'(RECENT_COUNT - 1)) ? '0 : ptr + PW'(1);
    end
  end

  // Match each candidate line against every valid slot.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    hit3 = 1'b0;
    for (int i = 0; i < RECENT_COUNT; i++) begin
      if (vld[i] && lines[i] == line1) hit1 = 1'b1;
      if (vld[i] && lines[i] == line2) hit2 = 1'b1;
      if (vld[i] && lines[i] == line3) hit3 = 1'b1;
    end
  end

endmodule

// File: rtl/pref_issue_queue.sv
// Prefetch issue queue: aligns up to three candidates per cycle to cache
// lines, drops duplicates (queue, recent filter, same cycle), buffers the
// survivors in a circular FIFO and issues the head over valid/ready.
// Optional statistics counters are built when PREF_Q_STATS_EN is defined.
module pref_issue_queue
  import pref_pkg::*;
#(
  parameter int DEPTH        = DEF_DEPTH,
  parameter int LINE_BITS    = DEF_LINE_BITS,
  parameter int RECENT_COUNT = DEF_RECENT_COUNT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pref_addr1_i,
  input  logic [63:0] pref_addr2_i,
  input  logic [63:0] pref_addr3_i,
  input  logic        pref_valid1_i,
  input  logic        pref_valid2_i,
  input  logic        pref_valid3_i,
  output logic        req_valid_o,
  output logic [63:0] req_addr_o,
  input  logic        req_ready_i,
`ifdef PREF_Q_STATS_EN
  output logic [31:0] drop_cnt_o,
  output logic [31:0] issue_cnt_o,
`endif
  output logic        full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  addr_t           mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            pop;

  addr_t           cand_line [3];
  logic [2:0]      cand_vld;
  logic [2:0]      filt_hit;
  logic [2:0]      q_hit;
  logic [2:0]      surv;
  logic [DEPTH-1:0] ent_vld;
  logic [CW:0]     free;
  logic [2:0]      push_en;
  logic [AW-1:0]   push_idx [3];
  logic [1:0]      n_push;
  logic [1:0]      n_drop;

  assign req_valid_o = (count != '0);
  assign req_addr_o  = mem[rd_ptr];
  assign full_o      = (count == CW'(DEPTH));
  assign pop         = req_valid_o & req_ready_i;

  // Align candidates; all compares and storage use the line address.
  always_comb begin
    cand_line[0] = line_align(pref_addr1_i, LINE_BITS);
    cand_line[1] = line_align(pref_addr2_i, LINE_BITS);
    cand_line[2] = line_align(pref_addr3_i, LINE_BITS);
    cand_vld     = {pref_valid3_i, pref_valid2_i, pref_valid1_i};
  end

  pref_recent_filter #(.RECENT_COUNT(RECENT_COUNT)) u_filter (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (pop),
    .wr_line (req_addr_o),
    .line1   (cand_line[0]),
    .line2   (cand_line[1]),
    .line3   (cand_line[2]),
    .hit1    (filt_hit[0]),
    .hit2    (filt_hit[1]),
    .hit3    (filt_hit[2])
  );

  // An entry is live if its distance from the read pointer is below count;
  // the head being popped this cycle still counts as live for dedup.
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      ent_vld[i] = ({1'b0, AW'(i) - rd_ptr} < count);
  end

  // Dedup against queue, filter and higher-priority candidates, then
  // allocate slots in priority order until free space runs out.
  always_comb begin
    q_hit    = '0;
    n_push   = '0;
    n_drop   = '0;
    push_en  = '0;
    for (int k = 0; k < 3; k++) push_idx[k] = '0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < DEPTH; i++)
        if (ent_vld[i] && mem[i] == cand_line[k]) q_hit[k] = 1'b1;
    surv[0] = cand_vld[0] & ~q_hit[0] & ~filt_hit[0];
    surv[1] = cand_vld[1] & ~q_hit[1] & ~filt_hit[1]
            & ~(cand_vld[0] && cand_line[0] == cand_line[1]);
    surv[2] = cand_vld[2] & ~q_hit[2] & ~filt_hit[2]
            & ~(cand_vld[0] && cand_line[0] == cand_line[2])
            & ~(cand_vld[1] && cand_line[1] == cand_line[2]);
    free = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(pop);
    for (int k = 0; k < 3; k++) begin
      if (surv[k]) begin
        if ((CW+1)'(n_push) < free) begin
          push_en[k]  = 1'b1;
          push_idx[k] = wr_ptr + AW'(n_push);
          n_push      = n_push + 2'd1;
        end else begin
          n_drop = n_drop + 2'd1;
        end
      end
    end
  end

  // FIFO storage, pointers and occupancy; reset flushes everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int k = 0; k < 3; k++)
        if (push_en[k]) mem[push_idx[k]] <= cand_line[k];
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      wr_ptr <= wr_ptr + AW'(n_push);
      count  <= count + CW'(n_push) - CW'(pop);
    end
  end

`ifdef PREF_Q_STATS_EN
  // Space-drop and issue counters, both wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_cnt_o  <= '0;
      issue_cnt_o <= '0;
    end else begin
      drop_cnt_o  <= drop_cnt_o + 32'(n_drop);
      issue_cnt_o <= issue_cnt_o + 32'(pop);
    end
  end
`else
  logic unused_stats;
  assign unused_stats = ^n_drop;
`endif

endmodule

// File: tb/tb_pref_issue_queue.sv
// Directed bench for pref_issue_queue with hand-computed expectations.
module tb_pref_issue_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] a1, a2, a3;
  logic        v1, v2, v3;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        ready;
  logic        full;
`ifdef PREF_Q_STATS_EN
  logic [31:0] drop_cnt;
  logic [31:0] issue_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pref_issue_queue dut (
    .clk           (clk),
    .rst           (rst),
    .pref_addr1_i  (a1),
    .pref_addr2_i  (a2),
    .pref_addr3_i  (a3),
    .pref_valid1_i (v1),
    .pref_valid2_i (v2),
    .pref_valid3_i (v3),
    .req_valid_o   (req_valid),
    .req_addr_o    (req_addr),
    .req_ready_i   (ready),
`ifdef PREF_Q_STATS_EN
    .drop_cnt_o    (drop_cnt),
    .issue_cnt_o   (issue_cnt),
`endif
    .full_o        (full)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of candidates and ready, then sample 1ns after the edge.
  task automatic step(input logic [2:0] v, input logic [63:0] x1, input logic [63:0] x2,
                      input logic [63:0] x3, input logic rdy);
    v1 = v[0]; v2 = v[1]; v3 = v[2];
    a1 = x1; a2 = x2; a3 = x3;
    ready = rdy;
    @(posedge clk);
    #1;
    v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
  endtask

  task automatic idle(input logic rdy);
    step(3'b000, 64'h0, 64'h0, 64'h0, rdy);
  endtask

  initial begin
    rst = 1'b0;
    v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
    a1 = '0; a2 = '0; a3 = '0;
    ready = 1'b0;
    idle(1'b0);
    idle(1'b0);
    check("rst_valid", {63'd0, req_valid}, 64'd0);
    check("rst_addr",  req_addr, 64'd0);
    check("rst_full",  {63'd0, full}, 64'd0);
    rst = 1'b1;

    // single candidate, aligned and issued immediately
    step(3'b001, 64'h1005, 64'h0, 64'h0, 1'b1);
    check("single_valid", {63'd0, req_valid}, 64'd1);
    check("single_addr",  req_addr, 64'h1000);
    idle(1'b1);
    check("single_empty", {63'd0, req_valid}, 64'd0);
`ifdef PREF_Q_STATS_EN
    check("single_issue_cnt", {32'd0, issue_cnt}, 64'd1);
`endif

    // same-cycle duplicates: 0x203F aligns onto 0x2000
    step(3'b111, 64'h2000, 64'h203F, 64'h2040, 1'b0);
    check("dup_head0", req_addr, 64'h2000);
    check("dup_full",  {63'd0, full}, 64'd0);
    idle(1'b1);
    check("dup_head1_valid", {63'd0, req_valid}, 64'd1);
    check("dup_head1", req_addr, 64'h2040);
    idle(1'b1);
    check("dup_drained", {63'd0, req_valid}, 64'd0);

    // filter dedup: 0x3010 hits the recently issued 0x3000
    step(3'b001, 64'h3000, 64'h0, 64'h0, 1'b0);
    check("filt_head", req_addr, 64'h3000);
    idle(1'b1);
    step(3'b001, 64'h3010, 64'h0, 64'h0, 1'b0);
    check("filt_dropped", {63'd0, req_valid}, 64'd0);
`ifdef PREF_Q_STATS_EN
    check("filt_drop_cnt", {32'd0, drop_cnt}, 64'd0);
`endif

    // queue dedup: 0x5020 matches queued 0x5000, 0x6000 is new
    step(3'b001, 64'h5000, 64'h0, 64'h0, 1'b0);
    step(3'b011, 64'h5020, 64'h6000, 64'h0, 1'b0);
    check("qdup_head0", req_addr, 64'h5000);
    idle(1'b1);
    check("qdup_head1", req_addr, 64'h6000);
    idle(1'b1);
    check("qdup_drained", {63'd0, req_valid}, 64'd0);

    // overflow: 9 distinct lines into 8 slots, last slot3 dropped
    step(3'b111, 64'h10000, 64'h11000, 64'h12000, 1'b0);
    step(3'b111, 64'h13000, 64'h14000, 64'h15000, 1'b0);
    check("ovf_not_full", {63'd0, full}, 64'd0);
    step(3'b111, 64'h16000, 64'h17000, 64'h18000, 1'b0);
    check("ovf_full", {63'd0, full}, 64'd1);
    check("ovf_head", req_addr, 64'h10000);
`ifdef PREF_Q_STATS_EN
    check("ovf_drop_cnt", {32'd0, drop_cnt}, 64'd1);
`endif

    // full with simultaneous pop: new line takes the freed slot
    step(3'b001, 64'h19000, 64'h0, 64'h0, 1'b1);
    check("fpop_full", {63'd0, full}, 64'd1);
    check("fpop_head", req_addr, 64'h11000);
`ifdef PREF_Q_STATS_EN
    check("fpop_drop_cnt", {32'd0, drop_cnt}, 64'd1);
`endif
    idle(1'b1);
    check("drain_full", {63'd0, full}, 64'd0);
    check("drain_head0", req_addr, 64'h12000);
    idle(1'b1);
    idle(1'b1);
    check("drain_head2", req_addr, 64'h14000);

    // mid-stream reset at count 5, with a candidate in the reset cycle
    rst = 1'b0;
    step(3'b001, 64'h20000, 64'h0, 64'h0, 1'b0);
    rst = 1'b1;
    check("mrst_valid", {63'd0, req_valid}, 64'd0);
    check("mrst_full",  {63'd0, full}, 64'd0);
    idle(1'b0);
    check("mrst_ignored", {63'd0, req_valid}, 64'd0);
`ifdef PREF_Q_STATS_EN
    check("mrst_issue_cnt", {32'd0, issue_cnt}, 64'd0);
`endif

    // 0x13000 was in the filter before reset; now accepted
    step(3'b001, 64'h13000, 64'h0, 64'h0, 1'b0);
    check("post_rst_valid", {63'd0, req_valid}, 64'd1);
    check("post_rst_addr",  req_addr, 64'h13000);
    idle(1'b1);
    check("last_pop_empty", {63'd0, req_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
